// File: rtl/comparator_pkg.sv
// Shared types and helpers for the chunked sequential comparator.
// Holds the comparison-mode encoding, FSM states and result mapping.
package comparator_pkg;

  typedef enum logic [2:0] {
    CMP_EQ  = 3'd0,
    CMP_NE  = 3'd1,
    CMP_LT  = 3'd2,
    CMP_LTU = 3'd3,
    CMP_GE  = 3'd4,
    CMP_GEU = 3'd5
  } cmp_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } cmp_state_t;

  // Signed modes only change how the top chunk is compared.
  function automatic logic is_signed_mode(
    input logic [2:0] m
  );
    return (m == CMP_LT) || (m == CMP_GE);
  endfunction

  // Map final equal/less-than flags onto the requested mode.
  // Codes 6 and 7 are unassigned and always report false.
  function automatic logic cmp_result(
    input logic [2:0] m,
    input logic       eq,
    input logic       lt
  );
    logic r;
    case (m)
      CMP_EQ:  r = eq;
      CMP_NE:  r = ~eq;
      CMP_LT:  r = lt;
      CMP_LTU: r = lt;
      CMP_GE:  r = ~lt;
      CMP_GEU: r = ~lt;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/comparator_chunk.sv
// Combinational W-bit chunk comparator.
// Reports equality plus unsigned and signed less-than.
module comparator_chunk #(
  parameter int W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic         eq_o,
  output logic         ltu_o,
  output logic         lts_o
);

  assign eq_o  = (a_i == b_i);
  assign ltu_o = (a_i < b_i);
  assign lts_o = ($signed(a_i) < $signed(b_i));

endmodule

// File: rtl/comparator_seq.sv
// Sequential comparator: walks W-bit chunks LSB first, one per cycle.
// Valid/ready on both sides, one operation in flight at a time.
module comparator_seq
  import comparator_pkg::*;
#(
  parameter int N = 32,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [2:0]   mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out
);

  localparam int K  = N / W;
  localparam int IW = (K > 1) ? $clog2(K) : 1;
  localparam logic [IW-1:0] LAST = IW'(K - 1);

  cmp_state_t    state_q;
  logic [N-1:0]  a_q;
  logic [N-1:0]  b_q;
  logic [2:0]    mode_q;
  logic [IW-1:0] idx_q;
  logic          eq_q;
  logic          lt_q;
  logic          out_q;

  logic [W-1:0]  ca;
  logic [W-1:0]  cb;
  logic          ch_eq;
  logic          ch_ltu;
  logic          ch_lts;
  logic          ch_lt;
  logic          is_msb;
  logic          eq_d;
  logic          lt_d;

  // Select the current chunk of both held operands.
  always_comb begin
    ca = '0;
    cb = '0;
    for (int k = 0; k < K; k++) begin
      if (idx_q == IW'(k)) begin
        ca = a_q[k*W +: W];
        cb = b_q[k*W +: W];
      end
    end
  end

  comparator_chunk #(
    .W (W)
  ) u_chunk (
    .a_i   (ca),
    .b_i   (cb),
    .eq_o  (ch_eq),
    .ltu_o (ch_ltu),
    .lts_o (ch_lts)
  );

  assign is_msb = (idx_q == LAST);
  assign ch_lt  = (is_msb && is_signed_mode(mode_q))
                ? ch_lts : ch_ltu;

  // Fold this chunk into the running flags.
  always_comb begin
    eq_d = eq_q & ch_eq;
    lt_d = ch_lt | (ch_eq & lt_q);
  end

  // Control FSM with operand, accumulator and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      mode_q  <= '0;
      idx_q   <= '0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
      out_q   <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            mode_q  <= mode;
            idx_q   <= '0;
            eq_q    <= 1'b1;
            lt_q    <= 1'b0;
            state_q <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          eq_q <= eq_d;
          lt_q <= lt_d;
          if (is_msb) begin
            out_q   <= cmp_result(mode_q, eq_d, lt_d);
            state_q <= ST_DONE;
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_q   <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign out       = out_q;

endmodule

// File: tb/tb_comparator_seq.sv
// Directed bench for comparator_seq (N=32, W=8).
// Checks latency, modes, backpressure and mid-operation reset.
module tb_comparator_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  mode;
  logic        out_valid;
  logic        out_ready;
  logic        out;

  int n_chk;
  int n_pass;

  comparator_seq #(
    .N (32),
    .W (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  // Issue one request, scramble inputs after accept,
  // then measure latency and result and complete the handshake.
  task automatic do_op(
    input string       tag,
    input logic [31:0] va,
    input logic [31:0] vb,
    input logic [2:0]  vm,
    input logic        exp
  );
    int lat;
    @(negedge clk);
    a = va; b = vb; mode = vm;
    in_valid = 1'b1; out_ready = 1'b1;
    chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom; mode = 3'($urandom);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'd4);
    chk({tag, "_out"}, 32'(out), 32'(exp));
    @(posedge clk);
    #1;
    chk({tag, "_rel"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int seen;
    n_chk = 0; n_pass = 0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; mode = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out", 32'(out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op("eq_same", 32'hDEADBEEF, 32'hDEADBEEF, 3'd0, 1'b1);
    do_op("ne_same", 32'hDEADBEEF, 32'hDEADBEEF, 3'd1, 1'b0);
    do_op("lt_m1_1", 32'hFFFFFFFF, 32'h00000001, 3'd2, 1'b1);
    do_op("ltu_m1_1", 32'hFFFFFFFF, 32'h00000001, 3'd3, 1'b0);
    do_op("ge_m1_1", 32'hFFFFFFFF, 32'h00000001, 3'd4, 1'b0);
    do_op("geu_m1_1", 32'hFFFFFFFF, 32'h00000001, 3'd5, 1'b1);
    do_op("lt_1_m1", 32'h00000001, 32'hFFFFFFFF, 3'd2, 1'b0);
    do_op("ltu_1_m1", 32'h00000001, 32'hFFFFFFFF, 3'd3, 1'b1);
    do_op("lt_min", 32'h80000000, 32'h7FFFFFFF, 3'd2, 1'b1);
    do_op("ltu_hi", 32'h00000100, 32'h000000FF, 3'd3, 1'b0);
    do_op("ge_eq", 32'h80000000, 32'h80000000, 3'd4, 1'b1);
    do_op("ltu_low", 32'h12345600, 32'h12345601, 3'd3, 1'b1);
    do_op("eq_low", 32'h12345600, 32'h12345601, 3'd0, 1'b0);
    do_op("mode6", 32'h12345600, 32'h12345601, 3'd6, 1'b0);
    do_op("mode7", 32'h00000000, 32'h00000001, 3'd7, 1'b0);

    // Backpressure: hold DONE while inputs keep moving.
    @(negedge clk);
    a = 32'h00000005; b = 32'h00000009; mode = 3'd3;
    in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1;
    seen = 0;
    while (!out_valid && seen < 20) begin
      @(posedge clk);
      #1;
      seen++;
    end
    chk("bp_lat", 32'(seen), 32'd4);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      a = $urandom; b = $urandom; mode = 3'($urandom);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_out", 32'(out), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_rel_valid", 32'(out_valid), 32'd0);
    chk("bp_rel_ready", 32'(in_ready), 32'd1);

    // Reset two cycles after accept aborts the operation.
    @(negedge clk);
    a = 32'h1; b = 32'h1; mode = 3'd0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("abort_no_valid", 32'(seen), 32'd0);
    chk("abort_ready", 32'(in_ready), 32'd1);
    do_op("post_abort", 32'hCAFEF00D, 32'hCAFEF00D, 3'd0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
